// File: rtl/apple_spawner_if.sv
// Request/result bundle between the game-control FSM and the apple spawner.
interface apple_spawner_if #(
  parameter int unsigned N         = 100,
  parameter int unsigned CELL_BITS = 3,
  parameter int unsigned SBITS     = 7
);
  logic [N*CELL_BITS-1:0] field;
  logic                   req;
  logic                   seed_load;
  logic [15:0]            seed_in;
  logic                   busy;
  logic                   done;
  logic [SBITS-1:0]       apple_pos;
  logic                   apple_ok;
  logic                   no_space;

  modport master (
    output field, req, seed_load, seed_in,
    input  busy, done, apple_pos, apple_ok, no_space
  );

  modport slave (
    input  field, req, seed_load, seed_in,
    output busy, done, apple_pos, apple_ok, no_space
  );
endinterface

// File: rtl/apple_spawner.sv
// Sequential apple placer: snapshots the field, picks an LFSR start cell and
// walks downward with wrap to the first empty cell, flagging a full field.
module apple_spawner #(
  parameter int unsigned SIZE_X     = 10,
  parameter int unsigned SIZE_Y     = 10,
  parameter int unsigned CELL_BITS  = 3,
  parameter int unsigned EMPTY_CODE = 0,
  parameter logic [15:0] LFSR_INIT  = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  apple_spawner_if.slave  bus
);
  localparam int unsigned N     = SIZE_X * SIZE_Y;
  localparam int unsigned SBITS = $clog2(N);
  localparam int unsigned SB1   = SBITS + 1;

  localparam logic [15:0]          LFSR_MASK = 16'hB400;
  localparam logic [SBITS-1:0]     N_S       = SBITS'(N);
  localparam logic [SBITS-1:0]     LAST      = SBITS'(N - 1);
  localparam logic [SB1-1:0]       N_EXT     = SB1'(N);
  localparam logic [CELL_BITS-1:0] EMPTY     = CELL_BITS'(EMPTY_CODE);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                         state;
  logic [15:0]                    lfsr;
  logic [15:0]                    lfsr_step_c;
  logic [N-1:0][CELL_BITS-1:0]    snap;
  logic [SBITS-1:0]               idx;
  logic [SBITS-1:0]               cnt;
  logic [SBITS-1:0]               rnd_c;
  logic [SBITS-1:0]               start_c;

  // Galois step and start-cell fold into [0, N)
  always_comb begin
    lfsr_step_c = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    rnd_c       = lfsr[SBITS-1:0];
    start_c     = ({1'b0, rnd_c} >= N_EXT) ? (rnd_c - N_S) : rnd_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= LFSR_INIT;
      snap          <= '0;
      idx           <= '0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.apple_pos <= '0;
      bus.apple_ok  <= 1'b0;
      bus.no_space  <= 1'b0;
    end else begin
      // A zero seed would lock the LFSR, so it is forced to 1
      if (bus.seed_load) begin
        lfsr <= (bus.seed_in == 16'h0000) ? 16'h0001 : bus.seed_in;
      end else begin
        lfsr <= lfsr_step_c;
      end

      bus.done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req) begin
            snap     <= bus.field;
            idx      <= start_c;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (snap[idx] == EMPTY) begin
            bus.apple_pos <= idx;
            bus.apple_ok  <= 1'b1;
            bus.no_space  <= 1'b0;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else if (cnt == LAST) begin
            bus.apple_ok  <= 1'b0;
            bus.no_space  <= 1'b1;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            idx <= (idx == '0) ? LAST : (idx - SBITS'(1));
            cnt <= cnt + SBITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apple_spawner.sv
// Scoreboard bench for apple_spawner: expected results queued at request time,
// checked against each done pulse including its cycle of arrival.
module tb_apple_spawner;
  localparam int N = 100;

  typedef struct {
    logic [6:0] pos;
    logic       ok;
    logic       nosp;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  logic [6:0] last_pos = 7'd0;
  logic [2:0] cells [N];
  exp_t q[$];

  apple_spawner_if #(.N(100), .CELL_BITS(3), .SBITS(7)) bus ();

  apple_spawner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bus.field = '0;
    for (int i = 0; i < N; i++) bus.field[i*3 +: 3] = cells[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference pick: walk down from the folded start with wrap
  function automatic exp_t model(input logic [15:0] l);
    exp_t e;
    int   r = int'(l[6:0]);
    int   s = (r >= N) ? r - N : r;
    e.pos = last_pos; e.ok = 1'b0; e.nosp = 1'b1; e.due = N + 1;
    for (int k = 0; k < N; k++) begin
      int i = s - k;
      if (i < 0) i += N;
      if (cells[i] == 3'd0) begin
        e.pos = 7'(i); e.ok = 1'b1; e.nosp = 1'b0; e.due = k + 2;
        return e;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        check("spurious_done", 32'(n_done), 32'(n_done - 1));
      end else begin
        e = q.pop_front();
        check("apple_pos", 32'(bus.apple_pos), 32'(e.pos));
        check("apple_ok", 32'(bus.apple_ok), 32'(e.ok));
        check("no_space", 32'(bus.no_space), 32'(e.nosp));
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic fill(input logic [2:0] v);
    for (int i = 0; i < N; i++) cells[i] = v;
  endtask

  // Seed in one cycle, request in the next; ex.due carries latency when given
  task automatic spawn(input logic [15:0] seed, input bit use_model, input exp_t ex);
    logic [15:0] eff;
    @(posedge clk); #1;
    bus.seed_load = 1'b1; bus.seed_in = seed;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    eff = (seed == 16'h0000) ? 16'h0001 : seed;
    check("lfsr_seed", 32'(dut.lfsr), 32'(eff));
    bus.req = 1'b1;
    if (use_model) ex = model(eff);
    ex.due = cyc + ex.due;
    if (ex.ok) last_pos = ex.pos;
    q.push_back(ex);
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    if (q.size() != 0) begin
      check("timeout_pending", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pos"}, 32'(bus.apple_pos), 32'd0);
    check({tag, "_ok"}, 32'(bus.apple_ok), 32'd0);
    check({tag, "_nosp"}, 32'(bus.no_space), 32'd0);
    check({tag, "_lfsr"}, 32'(dut.lfsr), 32'hACE1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   nd;
    logic [15:0] l2;

    bus.req = 1'b0; bus.seed_load = 1'b0; bus.seed_in = 16'h0000;
    fill(3'd0);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Empty field: start cell taken directly
    e = '{pos: 7'd37, ok: 1'b1, nosp: 1'b0, due: 2};
    spawn(16'h0025, 1'b0, e);
    wait_idle(50);

    // Three occupied cells below start
    cells[37] = 3'd2; cells[36] = 3'd5; cells[35] = 3'd7;
    e = '{pos: 7'd34, ok: 1'b1, nosp: 1'b0, due: 5};
    spawn(16'h0025, 1'b0, e);
    wait_idle(50);

    // Wrap from cell 0 to N-1
    fill(3'd0);
    for (int i = 0; i <= 3; i++) cells[i] = 3'd4;
    e = '{pos: 7'd99, ok: 1'b1, nosp: 1'b0, due: 6};
    spawn(16'h0003, 1'b0, e);
    wait_idle(50);

    // Full field: no_space, position held
    fill(3'd1);
    e = '{pos: 7'd99, ok: 1'b0, nosp: 1'b1, due: N + 1};
    spawn(16'h0025, 1'b0, e);
    wait_idle(200);

    // Mid-scan field change and extra req are both ignored
    nd = n_done;
    spawn(16'h1234, 1'b1, e);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_scan", 32'(bus.busy), 32'd1);
    fill(3'd0);
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    wait_idle(200);
    repeat (10) @(posedge clk);
    #1;
    check("one_done_only", 32'(n_done - nd), 32'd1);

    // Zero seed becomes 1; all-empty field returns cell 1
    fill(3'd0);
    e = '{pos: 7'd1, ok: 1'b1, nosp: 1'b0, due: 2};
    spawn(16'h0000, 1'b0, e);
    wait_idle(50);

    // Start index above N folds down (r=0x7F -> 27)
    e = '{pos: 7'd27, ok: 1'b1, nosp: 1'b0, due: 2};
    spawn(16'h00FF, 1'b0, e);
    wait_idle(50);

    // Back-to-back: req held through the done cycle is re-accepted
    @(posedge clk); #1;
    bus.seed_load = 1'b1; bus.seed_in = 16'h0005;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    bus.req = 1'b1;
    e = model(16'h0005);
    e.due = cyc + e.due;
    q.push_back(e);
    l2 = lfsr_step(lfsr_step(16'h0005));
    e = model(l2);
    e.due = cyc + 2 + e.due;
    q.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    bus.req = 1'b0;
    wait_idle(50);

    // Random seeds and sparse fields against the reference model
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        cells[i] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 7)) : 3'd0;
      spawn(16'($urandom_range(0, 65535)), 1'b1, e);
      wait_idle(200);
    end

    // Reset mid-scan: no done, outputs back to reset values
    fill(3'd1);
    nd = n_done;
    @(posedge clk); #1;
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check("no_done_after_rst", 32'(n_done), 32'(nd));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
